// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serialises one byte per request onto the serial line. The frame is a start
// bit, 8 data bits LSB first, an optional even parity bit and 1 or 2 stop bits.
// Bit timing comes from the shared baud tick generator. A bit lasts
// TICKS_PER_BIT b_tick pulses, which is 8x oversampling by default.
//
// Parameters:
//   TICKS_PER_BIT  b_tick pulses per bit period (1..16)
//   PARITY_EN      0 = no parity bit, 1 = even parity bit after D7
//   STOP_BITS      number of stop bits, 1 or 2
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   b_tick      in   one-clk baud tick pulse
//   start_trig  in   transmit request, accepted only when idle
//   i_data      in   byte to send, sampled on the accepting edge
//   o_tx        out  registered serial line, idle high
//   o_tx_busy   out  high while a frame is in progress
//   o_tx_done   out  one-clk pulse when a frame completes
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int TICKS_PER_BIT = 8,
  parameter int PARITY_EN     = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic       start_trig,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_t     state_r, state_s;
  logic [3:0] tick_cnt_r, tick_cnt_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic       stop_cnt_r, stop_cnt_s;
  logic [7:0] shift_r, shift_s;
  logic [7:0] data_r, data_s;
  logic       tx_r, tx_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       advance_s;

  // Bit advance: the last tick of the current bit period.
  always_comb begin
    advance_s = 1'b0;
    if (b_tick && (tick_cnt_r == TICK_LAST)) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_s    = state_r;
    tick_cnt_s = tick_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    stop_cnt_s = stop_cnt_r;
    shift_s    = shift_r;
    data_s     = data_r;
    tx_s       = tx_r;
    busy_s     = busy_r;
    done_s     = 1'b0;

    // Tick counting for every non-idle state; wraps on the bit advance.
    if (state_r != ST_IDLE) begin
      if (advance_s) begin
        tick_cnt_s = 4'd0;
      end else if (b_tick) begin
        tick_cnt_s = tick_cnt_r + 4'd1;
      end else begin
        tick_cnt_s = tick_cnt_r;
      end
    end else begin
      tick_cnt_s = 4'd0;
    end

    case (state_r)
      ST_IDLE: begin
        tx_s       = 1'b1;
        bit_cnt_s  = 3'd0;
        stop_cnt_s = 1'b0;
        busy_s     = 1'b0;
        // A tick on the accepting edge is not counted toward START.
        if (start_trig) begin
          state_s = ST_START;
          shift_s = i_data;
          data_s  = i_data;
          tx_s    = 1'b0;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (advance_s) begin
          state_s = ST_DATA;
          tx_s    = shift_r[0];
        end else begin
          state_s = ST_START;
        end
      end

      ST_DATA: begin
        if (advance_s) begin
          shift_s   = {1'b0, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            if (PARITY_EN == 1) begin
              state_s = ST_PARITY;
              tx_s    = even_parity(data_r);
            end else begin
              state_s = ST_STOP;
              tx_s    = 1'b1;
            end
          end else begin
            state_s = ST_DATA;
            // Line shows the bit that becomes shift[0] after this shift.
            tx_s    = shift_r[1];
          end
        end else begin
          state_s = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (advance_s) begin
          state_s = ST_STOP;
          tx_s    = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
      end

      ST_STOP: begin
        if (advance_s) begin
          if (stop_cnt_r == STOP_LAST) begin
            state_s    = ST_IDLE;
            tx_s       = 1'b1;
            busy_s     = 1'b0;
            done_s     = 1'b1;
            stop_cnt_s = 1'b0;
            bit_cnt_s  = 3'd0;
          end else begin
            state_s    = ST_STOP;
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        tick_cnt_s = 4'd0;
        bit_cnt_s  = 3'd0;
        stop_cnt_s = 1'b0;
        tx_s       = 1'b1;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State and output registers; the line changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= 4'd0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      shift_r    <= 8'd0;
      data_r     <= 8'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      stop_cnt_r <= stop_cnt_s;
      shift_r    <= shift_s;
      data_r     <= data_s;
      tx_r       <= tx_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign o_tx      = tx_r;
  assign o_tx_busy = busy_r;
  assign o_tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Drives two transmitters: one in the default 8N1 configuration and one with
// even parity and two stop bits. A frame-level reference model checks every
// output on every clock. The model is a list of line levels per bit period,
// indexed by the number of b_ticks counted since acceptance.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int TPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_tick;
  logic       start0, start1;
  logic [7:0] data;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;

  always #5 clk = ~clk;

  uart_tx #(.TICKS_PER_BIT(TPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .start_trig(start0), .i_data(data),
    .o_tx(tx0), .o_tx_busy(busy0), .o_tx_done(done0)
  );

  uart_tx #(.TICKS_PER_BIT(TPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .start_trig(start1), .i_data(data),
    .o_tx(tx1), .o_tx_busy(busy1), .o_tx_done(done1)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state per unit
  int   cfg_par[2]  = '{0, 1};
  int   cfg_stop[2] = '{1, 2};
  bit   m_active[2];
  int   m_ticks[2];
  int   m_nbits[2];
  bit   m_bits[2][12];
  logic m_tx[2];
  logic m_busy[2];
  logic m_done[2];
  logic [1:0] div;

  // Advance the model of unit u by one clock edge, given the inputs at that edge.
  task automatic model_edge(input int u, input bit st, input bit tk,
                            input logic [7:0] d, input bit r);
    int ones;
    int n;
    m_done[u] = 1'b0;
    if (r) begin
      m_active[u] = 1'b0;
      m_tx[u]     = 1'b1;
      m_busy[u]   = 1'b0;
    end else if (!m_active[u]) begin
      if (st) begin
        ones = 0;
        m_bits[u][0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
          m_bits[u][1+i] = d[i];
          ones += int'(d[i]);
        end
        n = 9;
        if (cfg_par[u] != 0) begin
          m_bits[u][9] = bit'(ones % 2);
          n = 10;
        end
        for (int s = 0; s < cfg_stop[u]; s++) m_bits[u][n+s] = 1'b1;
        m_nbits[u]  = n + cfg_stop[u];
        m_active[u] = 1'b1;
        m_ticks[u]  = 0;
        m_tx[u]     = 1'b0;
        m_busy[u]   = 1'b1;
      end else begin
        m_tx[u]   = 1'b1;
        m_busy[u] = 1'b0;
      end
    end else if (tk) begin
      m_ticks[u]++;
      if (m_ticks[u] == m_nbits[u] * TPB) begin
        m_active[u] = 1'b0;
        m_tx[u]     = 1'b1;
        m_busy[u]   = 1'b0;
        m_done[u]   = 1'b1;
      end else begin
        m_tx[u] = m_bits[u][m_ticks[u] / TPB];
      end
    end
  endtask

  task automatic chk(input string tag, input int u, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[u%0d] observed=%b expected=%b t=%0t", tag, u, obs, exp, $time);
    end
  endtask

  // One clock: drive the tick, clock the DUTs and the model, then compare.
  task automatic step();
    b_tick = (div == 2'd3);
    div++;
    @(posedge clk);
    model_edge(0, start0, b_tick, data, rst);
    model_edge(1, start1, b_tick, data, rst);
    #1;
    chk("tx",   0, tx0,   m_tx[0]);
    chk("busy", 0, busy0, m_busy[0]);
    chk("done", 0, done0, m_done[0]);
    chk("tx",   1, tx1,   m_tx[1]);
    chk("busy", 1, busy1, m_busy[1]);
    chk("done", 1, done1, m_done[1]);
  endtask

  task automatic set_start(input int u, input logic v);
    if (u == 0) start0 = v;
    else        start1 = v;
  endtask

  // Send one byte on unit u and run until the frame completes.
  task automatic run_frame(input int u, input logic [7:0] b);
    set_start(u, 1'b1);
    data = b;
    step();
    set_start(u, 1'b0);
    data = 8'($urandom);
    for (int k = 0; k < 600 && m_active[u]; k++) step();
    step();
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    data   = 8'h5A;
    b_tick = 1'b0;
    div    = 2'($urandom);
    for (int u = 0; u < 2; u++) begin
      m_active[u] = 1'b0;
      m_ticks[u]  = 0;
      m_nbits[u]  = 0;
    end

    // Reset held 3 clocks with start requested
    repeat (3) step();
    rst    = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (2) step();

    // Default frame and parity frame
    run_frame(0, 8'h55);
    run_frame(1, 8'hA3);

    // Request while busy is ignored
    start0 = 1'b1;
    data   = 8'h0F;
    step();
    start0 = 1'b0;
    repeat (120) step();
    start0 = 1'b1;
    data   = 8'hFF;
    step();
    start0 = 1'b0;
    for (int k = 0; k < 600 && m_active[0]; k++) step();
    repeat (3) step();

    // Back-to-back frames with start held high
    start0 = 1'b1;
    data   = 8'h00;
    step();
    data   = 8'hFF;
    for (int k = 0; k < 600 && m_active[0]; k++) step();
    step();
    start0 = 1'b0;
    data   = 8'h12;
    for (int k = 0; k < 600 && m_active[0]; k++) step();
    repeat (2) step();

    // Reset during D3 of 0x81, then a clean frame
    start0 = 1'b1;
    data   = 8'h81;
    step();
    start0 = 1'b0;
    for (int k = 0; k < 600 && m_ticks[0] < 4 * TPB + 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    run_frame(0, 8'h3C);

    // Random bytes at random tick phases on both units
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) step();
      run_frame(i % 2, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one byte per request onto the `tx` line as 8N1 by default (start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits). It shares the baud tick generator with the UART receiver. It uses that generator's 8×-bit-rate `b_tick`, so the receiver's sample points land mid-bit. The block sits between the command/response logic, which supplies bytes, and the TX pad.

## Interface
- `TICKS_PER_BIT`, 8: `b_tick` pulses per bit period; must match the shared tick generator (8× oversampling).
- `PARITY_EN`, 0: 0 = no parity bit; 1 = even parity bit inserted after D7.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `b_tick`  in  1  one-`clk`-wide baud tick pulse, TICKS_PER_BIT per bit period.
- `start_trig`  in  1  transmit request; sampled every `clk`, accepted only in IDLE.
- `i_data`  in  8  byte to send; sampled on the accepting edge only.
- `o_tx`  out  1  serial line, registered, idle high.
- `o_tx_busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `o_tx_done`  out  1  one-`clk` pulse at frame completion.

## Operation
- States:
  - IDLE: `o_tx`=1, counters cleared.
  - START: `o_tx`=0.
  - DATA: `o_tx`=shift[0].
  - PARITY: `o_tx`=^data; entered only when PARITY_EN=1.
  - STOP: `o_tx`=1.
- IDLE→START: on `start_trig`=1, independent of `b_tick`.
  - `i_data` is latched into the shift and data registers.
  - Tick counter and bit counter are cleared.
- Bit timing: each non-IDLE state holds for exactly TICKS_PER_BIT `b_tick` pulses.
  - The 4-bit tick counter increments on `b_tick`.
  - On the `b_tick` where the counter equals TICKS_PER_BIT−1, the counter clears and the bit advances.
- START → DATA after one bit period.
- DATA: each bit advance shifts the register right by one and increments the 3-bit bit counter.
  - On the 8th advance (bit counter = 7), go to PARITY if PARITY_EN=1, else STOP.
- PARITY → STOP after one bit period.
- STOP: lasts STOP_BITS bit periods; a stop counter tracks them.
  - On the final advance, go to IDLE and register `o_tx_done`=1 for that transition.
- `o_tx` is driven from a register updated alongside the state, so the line changes exactly on the edge where the state changes; no combinational glitches on the pad.
- `start_trig` while busy: ignored, not queued.
  - `i_data` changes while busy do not affect the frame in flight.
- Back-to-back frames: `start_trig` asserted in the same cycle `o_tx_done`=1 (first IDLE cycle) is accepted.
  - START begins on the next edge; inter-frame idle time is 1 `clk`.
- `b_tick` coincident with the accepting edge is not counted toward the START bit.
- Reset, at any time including mid-frame: on the next rising edge, state=IDLE, `o_tx`=1, `o_tx_busy`=0, `o_tx_done`=0, all counters and registers 0. The partial frame is abandoned.

## Timing
- Reset values: `o_tx`=1, `o_tx_busy`=0, `o_tx_done`=0.
- Accept latency: `o_tx` falls and `o_tx_busy` rises on the edge after the `start_trig` sample.
- Bit period: exactly TICKS_PER_BIT `b_tick` pulses. Duration in `clk` depends on tick phase: first bit is (TICKS_PER_BIT−1)·P+1 to TICKS_PER_BIT·P clocks, later bits exactly TICKS_PER_BIT·P, where P = tick period in clocks.
- Frame length in bit periods: 1 + 8 + PARITY_EN + STOP_BITS (10 default).
- `o_tx_done` is high for exactly 1 `clk`, the same cycle `o_tx_busy` first reads 0.
- `o_tx_busy` never drops mid-frame except by reset.

## Test plan
- **Reset values.** Assert `rst` 3 clk with `start_trig`=1 → `o_tx`=1, `o_tx_busy`=0, `o_tx_done`=0 throughout; no frame starts until `rst`=0.
- **Default frame, 0x55.** `b_tick` every 4 clk, send 0x55 → line 0,1,0,1,0,1,0,1,0,1. Each bit is 32 clk (first ≥29). `o_tx_done` is a single pulse. Loopback into `uart_rx` yields `o_dout`=0xA5?→ no: yields 0x55 with `o_rx_done`.
- **Parity, 0xA3.** PARITY_EN=1, STOP_BITS=2, send 0xA3 → data bits 1,1,0,0,0,1,0,1, parity=0, then two stop bits. `o_tx_busy` spans 12 bit periods.
- **Ignore while busy.** Send 0x0F; mid-DATA pulse `start_trig` with `i_data`=0xFF → transmitted frame still 0x0F, exactly one `o_tx_done`.
- **Back-to-back.** Hold `start_trig`=1 with 0x00 then 0xFF → second START begins 1 clk after the first `o_tx_done`. Both bytes decode correctly.
- **Reset mid-frame.** Assert `rst` during bit D3 of 0x81 → `o_tx`=1 the next edge, no `o_tx_done`. A following send of 0x3C is clean.
